cpu_fetch_unit: RTL

CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

---
 rtl/cpu_pkg.sv | 18 +
 rtl/cpu_fetch_unit_if.sv | 33 +++
 rtl/cpu_fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and default sizing.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_RAM_LATENCY = 1;
    localparam int DEF_RESET_PC    = 0;

    // Wide enough for the largest supported RAM latency (15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Bundle of the fetch unit's RAM, redirect and instruction handshake signals.
interface cpu_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              run;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_out;
    logic              rw;
    logic [DATA_W-1:0] ram_data_in;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] instr_pc;
    logic [DATA_W-1:0] data_debug;

    // Fetch unit side.
    modport master (
        input  run, ram_data_out, redirect, redirect_pc, instr_ready,
        output ram_address, rw, ram_data_in, instr_valid, instruction, instr_pc, data_debug
    );

    // RAM / control / consumer side.
    modport slave (
        output run, ram_data_out, redirect, redirect_pc, instr_ready,
        input  ram_address, rw, ram_data_in, instr_valid, instruction, instr_pc, data_debug
    );

endinterface

// File: rtl/cpu_fetch_unit.sv
// Read-only instruction fetch unit: issues a RAM read, waits a fixed latency,
// then holds the word on a valid/ready handshake until the consumer takes it.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                RAM_LATENCY = DEF_RAM_LATENCY,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              wire_clock,
    input  logic              wire_reset_n,
    input  logic              wire_run,
    output logic [ADDR_W-1:0] bus_RAM_ADDRESS,
    input  logic [DATA_W-1:0] bus_RAM_DATA_OUT,
    output logic              wire_RW,
    output logic [DATA_W-1:0] bus_RAM_DATA_IN,
    input  logic              wire_redirect,
    input  logic [ADDR_W-1:0] bus_redirect_pc,
    output logic              wire_instr_valid,
    input  logic              wire_instr_ready,
    output logic [DATA_W-1:0] bus_instruction,
    output logic [ADDR_W-1:0] bus_instr_pc,
    output logic [DATA_W-1:0] data_debug
);

    localparam logic [CNT_W-1:0] LATENCY = CNT_W'(RAM_LATENCY);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic [ADDR_W-1:0] pc_next;

    assign accept  = wire_instr_valid & wire_instr_ready;
    assign pc_next = pc + ADDR_W'(1);

    assign wire_RW         = 1'b0;
    assign bus_RAM_DATA_IN = '0;

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below sees the pre-edge values of pc, count and valid.
    always_ff @(posedge wire_clock) begin
        // NOTE: reset is sampled on the clock edge, so it is a synchronous reset
        // and it wins over redirect and accept.
        if (!wire_reset_n) begin
            state            <= S_IDLE;
            pc               <= RESET_PC;
            bus_RAM_ADDRESS  <= RESET_PC;
            count            <= '0;
            wire_instr_valid <= 1'b0;
            bus_instruction  <= '0;
            bus_instr_pc     <= '0;
            data_debug       <= '0;
        end else begin
            if (accept) begin
                data_debug <= bus_instruction;
            end

            // Redirect discards whatever is in flight or held; accept above still counts.
            if (wire_redirect) begin
                pc               <= bus_redirect_pc;
                wire_instr_valid <= 1'b0;
                count            <= '0;
                state            <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (wire_run) begin
                            bus_RAM_ADDRESS <= pc;
                            count           <= LATENCY;
                            state           <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            bus_instruction  <= bus_RAM_DATA_OUT;
                            bus_instr_pc     <= pc;
                            wire_instr_valid <= 1'b1;
                            state            <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (accept) begin
                            pc               <= pc_next;
                            wire_instr_valid <= 1'b0;
                            if (wire_run) begin
                                bus_RAM_ADDRESS <= pc_next;
                                count           <= LATENCY;
                                state           <= S_WAIT;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
